// File: rtl/match_lock_fsm.sv
// match_lock_fsm: tracks the comparator match bit on valid strobes, declares
// lock after LOCK_CNT consecutive matches and drops it after UNLOCK_CNT
// consecutive mismatches. Also keeps saturating match/mismatch statistics.
module match_lock_fsm #(
    parameter int unsigned LOCK_CNT   = 4,
    parameter int unsigned UNLOCK_CNT = 2,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             eq_in,
    output logic             locked,
    output logic             lock_pulse,
    output logic             unlock_pulse,
    output logic [CNT_W-1:0] run_len,
    output logic [CNT_W-1:0] match_total,
    output logic [CNT_W-1:0] mismatch_total,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        SEARCH  = 2'b00,
        ACQUIRE = 2'b01,
        LOCKED  = 2'b10,
        HOLD    = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] LOCK_V   = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0] UNLOCK_V = CNT_W'(UNLOCK_CNT);
    localparam logic [CNT_W-1:0] ONE_V    = CNT_W'(1);

    state_t           r_state;
    logic             r_locked;
    logic             r_lock_pulse;
    logic             r_unlock_pulse;
    logic [CNT_W-1:0] r_run_len;
    logic [CNT_W-1:0] r_match_total;
    logic [CNT_W-1:0] r_mismatch_total;
    logic [CNT_W-1:0] r_miss;

    logic [CNT_W-1:0] w_run_inc;
    logic [CNT_W-1:0] w_miss_inc;
    logic             w_run_max;
    logic             w_miss_max;
    logic             w_mt_max;
    logic             w_mm_max;

    assign w_run_inc  = r_run_len + ONE_V;
    assign w_miss_inc = r_miss + ONE_V;
    assign w_run_max  = &r_run_len;
    assign w_miss_max = &r_miss;
    assign w_mt_max   = &r_match_total;
    assign w_mm_max   = &r_mismatch_total;

    // Lock tracking state machine, statistics and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= SEARCH;
            r_locked         <= 1'b0;
            r_lock_pulse     <= 1'b0;
            r_unlock_pulse   <= 1'b0;
            r_run_len        <= '0;
            r_match_total    <= '0;
            r_mismatch_total <= '0;
            r_miss           <= '0;
        end else if (clear) begin
            r_state          <= SEARCH;
            r_locked         <= 1'b0;
            r_lock_pulse     <= 1'b0;
            r_unlock_pulse   <= 1'b0;
            r_run_len        <= '0;
            r_match_total    <= '0;
            r_mismatch_total <= '0;
            r_miss           <= '0;
        end else begin
            r_lock_pulse   <= 1'b0;
            r_unlock_pulse <= 1'b0;
            if (in_valid) begin
                if (eq_in) begin
                    if (!w_mt_max) r_match_total <= r_match_total + ONE_V;
                    r_miss <= '0;
                end else begin
                    if (!w_mm_max) r_mismatch_total <= r_mismatch_total + ONE_V;
                end

                case (r_state)
                    SEARCH: begin
                        if (eq_in) begin
                            r_run_len <= ONE_V;
                            if (LOCK_CNT == 1) begin
                                r_state      <= LOCKED;
                                r_locked     <= 1'b1;
                                r_lock_pulse <= 1'b1;
                            end else begin
                                r_state <= ACQUIRE;
                            end
                        end else begin
                            r_run_len <= '0;
                            if (!w_miss_max) r_miss <= w_miss_inc;
                        end
                    end
                    ACQUIRE: begin
                        if (eq_in) begin
                            r_run_len <= w_run_inc;
                            if (w_run_inc == LOCK_V) begin
                                r_state      <= LOCKED;
                                r_locked     <= 1'b1;
                                r_lock_pulse <= 1'b1;
                            end
                        end else begin
                            r_state   <= SEARCH;
                            r_run_len <= '0;
                            if (!w_miss_max) r_miss <= w_miss_inc;
                        end
                    end
                    LOCKED: begin
                        if (eq_in) begin
                            if (!w_run_max) r_run_len <= w_run_inc;
                        end else begin
                            r_run_len <= '0;
                            if (UNLOCK_CNT == 1) begin
                                r_state        <= SEARCH;
                                r_locked       <= 1'b0;
                                r_unlock_pulse <= 1'b1;
                                r_miss         <= '0;
                            end else begin
                                r_state <= HOLD;
                                r_miss  <= ONE_V;
                            end
                        end
                    end
                    HOLD: begin
                        if (eq_in) begin
                            r_state   <= LOCKED;
                            r_run_len <= ONE_V;
                        end else if (w_miss_inc == UNLOCK_V) begin
                            r_state        <= SEARCH;
                            r_locked       <= 1'b0;
                            r_unlock_pulse <= 1'b1;
                            r_miss         <= '0;
                        end else begin
                            r_miss <= w_miss_inc;
                        end
                    end
                    default: r_state <= SEARCH;
                endcase
            end
        end
    end

    assign locked         = r_locked;
    assign lock_pulse     = r_lock_pulse;
    assign unlock_pulse   = r_unlock_pulse;
    assign run_len        = r_run_len;
    assign match_total    = r_match_total;
    assign mismatch_total = r_mismatch_total;
    assign state          = r_state;

endmodule

// File: tb/tb_match_lock_fsm.sv
// Directed bench for match_lock_fsm: a vector table for the main sequence plus
// hand-written sequences for async reset, saturation/clear and the
// single-sample lock/unlock boundary.
module tb_match_lock_fsm;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic in_valid = 1'b0;
    logic eq_in = 1'b0;

    always #5 clk = ~clk;

    // Default build: LOCK_CNT=4, UNLOCK_CNT=2, CNT_W=8
    logic       lk, lp, up;
    logic [7:0] run, mt, mm;
    logic [1:0] st;

    // Narrow counters for saturation
    logic       lk4, lp4, up4;
    logic [3:0] run4, mt4, mm4;
    logic [1:0] st4;

    // Single-sample lock and unlock
    logic       lk1, lp1, up1;
    logic [7:0] run1, mt1, mm1;
    logic [1:0] st1;

    match_lock_fsm #(.LOCK_CNT(4), .UNLOCK_CNT(2), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .eq_in(eq_in),
        .locked(lk), .lock_pulse(lp), .unlock_pulse(up), .run_len(run),
        .match_total(mt), .mismatch_total(mm), .state(st)
    );

    match_lock_fsm #(.LOCK_CNT(4), .UNLOCK_CNT(2), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .eq_in(eq_in),
        .locked(lk4), .lock_pulse(lp4), .unlock_pulse(up4), .run_len(run4),
        .match_total(mt4), .mismatch_total(mm4), .state(st4)
    );

    match_lock_fsm #(.LOCK_CNT(1), .UNLOCK_CNT(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .eq_in(eq_in),
        .locked(lk1), .lock_pulse(lp1), .unlock_pulse(up1), .run_len(run1),
        .match_total(mt1), .mismatch_total(mm1), .state(st1)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; eq_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Apply one sample at the falling edge, then sample outputs just after the rising edge
    task automatic step(input logic c, input logic v, input logic e);
        @(negedge clk);
        clear = c; in_valid = v; eq_in = e;
        @(posedge clk);
        #1;
        clear = 1'b0; in_valid = 1'b0; eq_in = 1'b0;
    endtask

    typedef struct {
        logic        clr;
        logic        v;
        logic        e;
        int unsigned st;
        int unsigned lk;
        int unsigned lp;
        int unsigned up;
        int unsigned run;
        int unsigned mt;
        int unsigned mm;
    } vec_t;

    vec_t vt[19];

    initial begin
        //          clr   v     e     st lk lp up run mt mm
        vt[0]  = '{1'b0, 1'b1, 1'b1, 1, 0, 0, 0, 1, 1, 0};
        vt[1]  = '{1'b0, 1'b1, 1'b1, 1, 0, 0, 0, 2, 2, 0};
        vt[2]  = '{1'b0, 1'b0, 1'b0, 1, 0, 0, 0, 2, 2, 0};
        vt[3]  = '{1'b0, 1'b1, 1'b1, 1, 0, 0, 0, 3, 3, 0};
        vt[4]  = '{1'b0, 1'b1, 1'b1, 2, 1, 1, 0, 4, 4, 0};
        vt[5]  = '{1'b0, 1'b0, 1'b1, 2, 1, 0, 0, 4, 4, 0};
        vt[6]  = '{1'b0, 1'b1, 1'b1, 2, 1, 0, 0, 5, 5, 0};
        vt[7]  = '{1'b0, 1'b1, 1'b0, 3, 1, 0, 0, 0, 5, 1};
        vt[8]  = '{1'b0, 1'b1, 1'b1, 2, 1, 0, 0, 1, 6, 1};
        vt[9]  = '{1'b0, 1'b1, 1'b0, 3, 1, 0, 0, 0, 6, 2};
        vt[10] = '{1'b0, 1'b0, 1'b0, 3, 1, 0, 0, 0, 6, 2};
        vt[11] = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 1, 0, 6, 3};
        vt[12] = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 6, 4};
        vt[13] = '{1'b0, 1'b1, 1'b1, 1, 0, 0, 0, 1, 7, 4};
        vt[14] = '{1'b0, 1'b1, 1'b1, 1, 0, 0, 0, 2, 8, 4};
        vt[15] = '{1'b0, 1'b1, 1'b1, 1, 0, 0, 0, 3, 9, 4};
        vt[16] = '{1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0, 9, 5};
        vt[17] = '{1'b1, 1'b1, 1'b1, 0, 0, 0, 0, 0, 0, 0};
        vt[18] = '{1'b0, 1'b1, 1'b1, 1, 0, 0, 0, 1, 1, 0};

        // Async reset asserted mid-cycle while acquiring
        do_reset();
        chk("reset_state", st, 0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("pre_reset_run", run, 2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_state", st, 0);
        chk("async_locked", lk, 0);
        chk("async_run", run, 0);
        chk("async_mt", mt, 0);
        chk("async_mm", mm, 0);
        chk("async_up", up, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Main table: lock, gaps, hold recovery, unlock, broken acquire, clear
        for (int i = 0; i < 19; i++) begin
            step(vt[i].clr, vt[i].v, vt[i].e);
            chk($sformatf("v%0d_state", i), st, vt[i].st);
            chk($sformatf("v%0d_locked", i), lk, vt[i].lk);
            chk($sformatf("v%0d_lock_pulse", i), lp, vt[i].lp);
            chk($sformatf("v%0d_unlock_pulse", i), up, vt[i].up);
            chk($sformatf("v%0d_run_len", i), run, vt[i].run);
            chk($sformatf("v%0d_match_total", i), mt, vt[i].mt);
            chk($sformatf("v%0d_mismatch_total", i), mm, vt[i].mm);
        end

        // Saturation on 4-bit counters, then clear overriding a valid mismatch
        do_reset();
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1);
        chk("sat_mt4", mt4, 15);
        chk("sat_run4", run4, 15);
        chk("sat_state4", st4, 2);
        chk("sat_mt8", mt, 20);
        chk("sat_run8", run, 20);
        step(1'b1, 1'b1, 1'b0);
        chk("clr_mt4", mt4, 0);
        chk("clr_mm4", mm4, 0);
        chk("clr_run4", run4, 0);
        chk("clr_state4", st4, 0);
        chk("clr_locked4", lk4, 0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0);
        chk("sat_mm4", mm4, 15);
        chk("sat_mm4_mt", mt4, 0);
        chk("sat_mm8", mm, 20);

        // LOCK_CNT=1 / UNLOCK_CNT=1: single sample locks and unlocks
        do_reset();
        step(1'b0, 1'b1, 1'b1);
        chk("b1_state", st1, 2);
        chk("b1_lp", lp1, 1);
        chk("b1_locked", lk1, 1);
        chk("b1_run", run1, 1);
        step(1'b0, 1'b0, 1'b0);
        chk("b1_lp_width", lp1, 0);
        step(1'b0, 1'b1, 1'b0);
        chk("b1_unlock_state", st1, 0);
        chk("b1_up", up1, 1);
        chk("b1_up_lp", lp1, 0);
        chk("b1_unlock_locked", lk1, 0);
        step(1'b0, 1'b1, 1'b1);
        chk("b1_relock_lp", lp1, 1);
        chk("b1_relock_up", up1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
